// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and default memory latency.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } arb_state_t;

  localparam int DEFAULT_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: shares one single-ported memory between
// instruction fetch and data memory. Each access holds the port for LAT
// cycles, returns registered read data with a one-cycle done pulse, and
// raises pipeline stalls while a requester is waiting. Data accesses win
// by default, but a fetch waiting behind a completed data access goes next.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int LAT = DEFAULT_LAT,
  parameter int AW  = 16,
  parameter int DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          busy
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          last_dm;
  logic          if_pend;
  logic          dm_pend;

  // A requester whose done pulse is showing this cycle is no longer waiting.
  always_comb begin
    if_pend   = if_req & ~if_done;
    dm_pend   = (dm_rd | dm_wr) & ~dm_done;
    stall_if  = if_pend;
    stall_mem = dm_pend;
    busy      = (state != IDLE);
    mem_en    = (state != IDLE);
  end

  // Arbitration, access timing, completion capture and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dm   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_pend && !(last_dm && if_pend)) begin
            state     <= DM_ACC;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_we    <= dm_wr;
            cnt       <= '0;
          end else if (if_pend) begin
            state     <= IF_ACC;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cnt       <= '0;
          end
        end
        IF_ACC, DM_ACC: begin
          if (cnt == CNT_LAST) begin
            if (state == IF_ACC) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_done <= 1'b1;
            end
            last_dm <= (state == DM_ACC);
            mem_we  <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with LAT=2.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  int compared;
  int mismatched;

  mem_port_arbiter #(.LAT(2), .AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Start of a new cycle: just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One comparison of an observed value against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; cycle numbers in comments count from request cycle 0.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    dm_rd      = 1'b0;
    dm_wr      = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    mem_rdata  = '0;

    // Reset state
    #2;
    checkOutput("rst_mem_en", mem_en, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_if_rdata", if_rdata, 16'h0000);
    checkOutput("rst_dm_done", dm_done, 1'b0);
    applyStimulus();
    rst = 1'b1;
    applyStimulus();

    // Fetch only at 0x0010
    applyStimulus();
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    checkOutput("f_c0_stall_if", stall_if, 1'b1);
    checkOutput("f_c0_mem_en", mem_en, 1'b0);
    applyStimulus();
    checkOutput("f_c1_mem_en", mem_en, 1'b1);
    checkOutput("f_c1_mem_addr", mem_addr, 16'h0010);
    checkOutput("f_c1_mem_we", mem_we, 1'b0);
    checkOutput("f_c1_busy", busy, 1'b1);
    applyStimulus();
    mem_rdata = 16'hB123;
    checkOutput("f_c2_mem_en", mem_en, 1'b1);
    checkOutput("f_c2_stall_if", stall_if, 1'b1);
    checkOutput("f_c2_if_done", if_done, 1'b0);
    applyStimulus();
    checkOutput("f_c3_if_done", if_done, 1'b1);
    checkOutput("f_c3_if_rdata", if_rdata, 16'hB123);
    checkOutput("f_c3_stall_if", stall_if, 1'b0);
    checkOutput("f_c3_mem_en", mem_en, 1'b0);
    if_req = 1'b0;
    applyStimulus();
    mem_rdata = 16'h0BAD;
    checkOutput("f_c4_if_done", if_done, 1'b0);
    checkOutput("f_c4_if_rdata_hold", if_rdata, 16'hB123);

    // Simultaneous fetch and load, data wins first
    applyStimulus();
    if_req = 1'b1; if_addr = 16'h0020;
    dm_rd  = 1'b1; dm_addr = 16'h0040;
    #1;
    checkOutput("s_c0_stall_mem", stall_mem, 1'b1);
    applyStimulus();
    checkOutput("s_c1_mem_addr", mem_addr, 16'h0040);
    checkOutput("s_c1_stall_if", stall_if, 1'b1);
    applyStimulus();
    mem_rdata = 16'h1111;
    applyStimulus();
    checkOutput("s_c3_dm_done", dm_done, 1'b1);
    checkOutput("s_c3_dm_rdata", dm_rdata, 16'h1111);
    checkOutput("s_c3_if_done", if_done, 1'b0);
    checkOutput("s_c3_stall_mem", stall_mem, 1'b0);
    dm_rd = 1'b0;
    applyStimulus();
    checkOutput("s_c4_mem_en", mem_en, 1'b1);
    checkOutput("s_c4_mem_addr", mem_addr, 16'h0020);
    checkOutput("s_c4_dm_done", dm_done, 1'b0);
    applyStimulus();
    mem_rdata = 16'h2222;
    applyStimulus();
    checkOutput("s_c6_if_done", if_done, 1'b1);
    checkOutput("s_c6_if_rdata", if_rdata, 16'h2222);
    checkOutput("s_c6_dm_rdata_hold", dm_rdata, 16'h1111);
    if_req = 1'b0;

    // Continuous loads against a waiting fetch: DM, IF, DM
    applyStimulus();
    if_req = 1'b1; if_addr = 16'h0030;
    dm_rd  = 1'b1; dm_addr = 16'h0050;
    applyStimulus();
    checkOutput("a_c1_mem_addr", mem_addr, 16'h0050);
    applyStimulus();
    mem_rdata = 16'h3333;
    applyStimulus();
    checkOutput("a_c3_dm_done", dm_done, 1'b1);
    applyStimulus();
    checkOutput("a_c4_mem_addr", mem_addr, 16'h0030);
    checkOutput("a_c4_mem_en", mem_en, 1'b1);
    applyStimulus();
    mem_rdata = 16'h4444;
    applyStimulus();
    checkOutput("a_c6_if_done", if_done, 1'b1);
    checkOutput("a_c6_if_rdata", if_rdata, 16'h4444);
    if_req = 1'b0;
    applyStimulus();
    checkOutput("a_c7_mem_addr", mem_addr, 16'h0050);
    applyStimulus();
    mem_rdata = 16'h5555;
    applyStimulus();
    checkOutput("a_c9_dm_done", dm_done, 1'b1);
    checkOutput("a_c9_dm_rdata", dm_rdata, 16'h5555);
    dm_rd = 1'b0;

    // Store 0xCAFE to 0x0100
    applyStimulus();
    dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hCAFE;
    applyStimulus();
    checkOutput("w_c1_mem_we", mem_we, 1'b1);
    checkOutput("w_c1_mem_wdata", mem_wdata, 16'hCAFE);
    checkOutput("w_c1_mem_addr", mem_addr, 16'h0100);
    applyStimulus();
    mem_rdata = 16'hDEAD;
    checkOutput("w_c2_mem_we", mem_we, 1'b1);
    checkOutput("w_c2_mem_wdata", mem_wdata, 16'hCAFE);
    applyStimulus();
    checkOutput("w_c3_dm_done", dm_done, 1'b1);
    checkOutput("w_c3_dm_rdata_hold", dm_rdata, 16'h5555);
    dm_wr = 1'b0;

    // Read and write together behave as a write
    applyStimulus();
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    applyStimulus();
    checkOutput("b_c1_mem_we", mem_we, 1'b1);
    checkOutput("b_c1_mem_wdata", mem_wdata, 16'h1234);
    applyStimulus();
    mem_rdata = 16'h7777;
    applyStimulus();
    checkOutput("b_c3_dm_done", dm_done, 1'b1);
    checkOutput("b_c3_dm_rdata_hold", dm_rdata, 16'h5555);
    dm_rd = 1'b0; dm_wr = 1'b0;

    // Reset during a fetch access, then a normal fetch afterwards
    applyStimulus();
    if_req = 1'b1; if_addr = 16'h0060;
    applyStimulus();
    checkOutput("r_c1_mem_en", mem_en, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("r_c1_mem_en_rst", mem_en, 1'b0);
    checkOutput("r_c1_mem_addr_rst", mem_addr, 16'h0000);
    checkOutput("r_c1_busy_rst", busy, 1'b0);
    checkOutput("r_c1_if_rdata_rst", if_rdata, 16'h0000);
    checkOutput("r_c1_dm_rdata_rst", dm_rdata, 16'h0000);
    applyStimulus();
    checkOutput("r_c2_if_done", if_done, 1'b0);
    checkOutput("r_c2_mem_en", mem_en, 1'b0);
    rst = 1'b1;
    applyStimulus();
    checkOutput("r_c3_mem_en", mem_en, 1'b1);
    checkOutput("r_c3_mem_addr", mem_addr, 16'h0060);
    applyStimulus();
    mem_rdata = 16'h6666;
    applyStimulus();
    checkOutput("r_c5_if_done", if_done, 1'b1);
    checkOutput("r_c5_if_rdata", if_rdata, 16'h6666);
    if_req = 1'b0;
    applyStimulus();
    checkOutput("r_c6_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
